audio_i2s_receiver: RTL and testbench

- I2S slave receiver: deserialises an external ADC/line-in stream (BCK, LRCK, DATA all driven externally) into parallel left/right sample pairs.
- Receive counterpart of the synth's I2S transmit path; feeds sampled audio into the synth engine domain (mixer input / future sampler).
- Runs entirely on OSC_CLK. All I2S inputs are oversampled and synchronised; BCK is never used as a clock.

---
 rtl/audio_i2s_receiver_pkg.sv | 35 +++
 rtl/audio_i2s_receiver_sync.sv | 53 +++++
 rtl/audio_i2s_receiver.sv | 171 +++++++++++++++++
 tb/tb_audio_i2s_receiver.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_i2s_receiver_pkg.sv
// Shared definitions for the I2S receive path.
//
// Contents:
//   rx_state_e   - receiver frame-alignment states (SYNC_WAIT / LEFT / RIGHT)
//   AUDIO_DATA_W - default captured word width; 24 when the build defines
//                  AUDIO_24BIT, otherwise 16
//   clog2        - ceiling log2 helper for sizing counters at elaboration
package audio_i2s_receiver_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } rx_state_e;

`ifdef AUDIO_24BIT
  localparam int AUDIO_DATA_W = 24;
`else
  localparam int AUDIO_DATA_W = 16;
`endif

  // Returns ceil(log2(value)); clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/audio_i2s_receiver_sync.sv
// i2s_in_sync: brings an externally clocked serial interface (bit clock,
// word select, data) into the system clock domain and detects bit-clock
// rising edges. The bit clock is treated purely as data, never as a clock.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   bck_in   in   raw external bit clock
//   lrck_in  in   raw external word select
//   dat_in   in   raw external serial data
//   bck_rise out  one-cycle pulse per synchronised bit-clock rising edge
//   lrck_s   out  synchronised word select, aligned with bck_rise
//   dat_s    out  synchronised data, aligned with bck_rise
module i2s_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bck_in,
  input  logic lrck_in,
  input  logic dat_in,
  output logic bck_rise,
  output logic lrck_s,
  output logic dat_s
);

  logic [STAGES-1:0] bck_sync;
  logic [STAGES-1:0] lrck_sync;
  logic [STAGES-1:0] dat_sync;
  logic              bck_d;

  // All three inputs pass through the same number of flops so LRCK and DATA
  // seen alongside bck_rise are the values present at the external BCK rise.
  // bck_d is the one extra stage used only for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bck_sync  <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bck_d     <= 1'b0;
    end else begin
      bck_sync  <= {bck_sync[STAGES-2:0], bck_in};
      lrck_sync <= {lrck_sync[STAGES-2:0], lrck_in};
      dat_sync  <= {dat_sync[STAGES-2:0], dat_in};
      bck_d     <= bck_sync[STAGES-1];
    end
  end

  assign bck_rise = bck_sync[STAGES-1] & ~bck_d;
  assign lrck_s   = lrck_sync[STAGES-1];
  assign dat_s    = dat_sync[STAGES-1];

endmodule

// File: rtl/audio_i2s_receiver.sv
// audio_i2s_receiver: I2S slave receiver running entirely on OSC_CLK.
// Deserialises an external ADC/line-in stream into left/right sample pairs
// and hands them to the synth engine through a valid/ready handshake.
//
// Ports:
//   OSC_CLK      in   system clock
//   reset_reg_N  in   asynchronous active-low reset
//   iAUD_BCK     in   external bit clock (oversampled, not used as a clock)
//   iAUD_LRCK    in   word select, 0 = left, 1 = right
//   iAUD_ADCDAT  in   serial data, MSB first, one BCK after the LRCK change
//   o_lsound_in  out  left sample, two's complement, left-justified
//   o_rsound_in  out  right sample, two's complement, left-justified
//   o_valid      out  a sample pair is available
//   i_ready      in   consumer takes the pair when o_valid && i_ready
//   o_overrun    out  sticky flag: an unconsumed pair was overwritten
//   i_clr_ovr    in   synchronous clear of o_overrun
module audio_i2s_receiver
  import audio_i2s_receiver_pkg::*;
#(
  parameter int DATA_W      = AUDIO_DATA_W,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              OSC_CLK,
  input  logic              reset_reg_N,
  input  logic              iAUD_BCK,
  input  logic              iAUD_LRCK,
  input  logic              iAUD_ADCDAT,
  output logic [DATA_W-1:0] o_lsound_in,
  output logic [DATA_W-1:0] o_rsound_in,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overrun,
  input  logic              i_clr_ovr
);

  localparam int CNT_W = clog2(SLOT_W) + 1;
  localparam int IDX_W = (DATA_W > 1) ? clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] DATA_W_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] SLOT_W_CNT = CNT_W'(SLOT_W);
  localparam logic [IDX_W-1:0] MSB_IDX    = IDX_W'(DATA_W - 1);

  logic              bck_rise;
  logic              lrck_s;
  logic              dat_s;

  rx_state_e         state_q;
  rx_state_e         state_d;
  logic              commit_left;
  logic              commit_right;

  logic              lrck_prev;
  logic              lrck_edge;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] l_hold;
  logic [DATA_W-1:0] r_word;
  logic              pub_req;

  i2s_in_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (OSC_CLK),
    .rst_n    (reset_reg_N),
    .bck_in   (iAUD_BCK),
    .lrck_in  (iAUD_LRCK),
    .dat_in   (iAUD_ADCDAT),
    .bck_rise (bck_rise),
    .lrck_s   (lrck_s),
    .dat_s    (dat_s)
  );

  // A change of the sampled word select marks the I2S delay bit: it closes
  // the slot that just ended and carries no data for the new one.
  assign lrck_edge = bck_rise & (lrck_s ^ lrck_prev);

  // MSB-first placement: bit n of the slot lands at DATA_W-1-n, so a short
  // slot leaves its uncaptured LSBs at zero.
  assign bit_idx = MSB_IDX - bit_cnt[IDX_W-1:0];

  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q <= SYNC_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame alignment. SYNC_WAIT only leaves on a 1->0 word-select edge so the
  // first pair published is always a complete left+right frame.
  always_comb begin
    state_d      = state_q;
    commit_left  = 1'b0;
    commit_right = 1'b0;
    if (lrck_edge) begin
      case (state_q)
        SYNC_WAIT: begin
          if (!lrck_s) state_d = LEFT;
        end
        LEFT: begin
          if (lrck_s) begin
            commit_left = 1'b1;
            state_d     = RIGHT;
          end
        end
        RIGHT: begin
          if (!lrck_s) begin
            commit_right = 1'b1;
            state_d      = LEFT;
          end
        end
        default: state_d = SYNC_WAIT;
      endcase
    end
  end

  // Bit capture and word holding. pub_req delays publication by one cycle so
  // the output registers load from the already-latched right word.
  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      lrck_prev <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      l_hold    <= '0;
      r_word    <= '0;
      pub_req   <= 1'b0;
    end else begin
      pub_req <= commit_right;
      if (commit_left)  l_hold <= shift_reg;
      if (commit_right) r_word <= shift_reg;
      if (bck_rise) begin
        lrck_prev <= lrck_s;
        if (lrck_edge) begin
          shift_reg <= '0;
          bit_cnt   <= '0;
        end else if (state_q != SYNC_WAIT) begin
          if (bit_cnt < DATA_W_CNT) shift_reg[bit_idx] <= dat_s;
          if (bit_cnt < SLOT_W_CNT) bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Output handshake. A publish always loads; the overrun flag is raised
  // only if the pair being replaced was not taken in the same cycle, and a
  // new overrun beats a simultaneous clear.
  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      o_lsound_in <= '0;
      o_rsound_in <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (pub_req) begin
        o_lsound_in <= l_hold;
        o_rsound_in <= r_word;
        o_valid     <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (pub_req && o_valid && !i_ready) begin
        o_overrun <= 1'b1;
      end else if (i_clr_ovr) begin
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Testbench for audio_i2s_receiver (DATA_W = 16, SLOT_W = 32, SYNC_STAGES = 2).
// Drives I2S slots with randomised bit-clock phases and data, and compares
// the DUT against a slot-level reference model of the receiver.
module tb_audio_i2s_receiver;

  localparam int DATA_W      = 16;
  localparam int SLOT_W      = 32;
  localparam int SYNC_STAGES = 2;

  logic              OSC_CLK = 1'b0;
  logic              reset_reg_N;
  logic              iAUD_BCK;
  logic              iAUD_LRCK;
  logic              iAUD_ADCDAT;
  logic [DATA_W-1:0] o_lsound_in;
  logic [DATA_W-1:0] o_rsound_in;
  logic              o_valid;
  logic              i_ready;
  logic              o_overrun;
  logic              i_clr_ovr;

  int tests    = 0;
  int failures = 0;

  // Pairs the DUT handed over, and pairs the model says it should have.
  logic [31:0] acc_q[$];
  logic [31:0] exp_acc_q[$];

  // Reference model state.
  logic        m_lrck;
  logic        m_have_left;
  logic        m_have_right;
  logic [15:0] m_lw;
  logic [15:0] m_rw;
  logic        m_valid;
  logic [15:0] m_l;
  logic [15:0] m_r;
  logic        m_ovr;

  audio_i2s_receiver #(
    .DATA_W      (DATA_W),
    .SLOT_W      (SLOT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .OSC_CLK     (OSC_CLK),
    .reset_reg_N (reset_reg_N),
    .iAUD_BCK    (iAUD_BCK),
    .iAUD_LRCK   (iAUD_LRCK),
    .iAUD_ADCDAT (iAUD_ADCDAT),
    .o_lsound_in (o_lsound_in),
    .o_rsound_in (o_rsound_in),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_overrun   (o_overrun),
    .i_clr_ovr   (i_clr_ovr)
  );

  always #5 OSC_CLK = ~OSC_CLK;

  // Record every pair the consumer takes.
  always @(posedge OSC_CLK) begin
    if (reset_reg_N && o_valid && i_ready) acc_q.push_back({o_lsound_in, o_rsound_in});
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // The first 16 bits of an n-bit slot, left-justified with zero fill.
  function automatic logic [15:0] justify(input logic [31:0] w, input int n);
    if (n >= 16) return 16'(w >> (n - 16));
    else         return 16'(w << (16 - n));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"},   32'(o_valid),     32'(m_valid));
    check({tag, ".left"},    32'(o_lsound_in), 32'(m_l));
    check({tag, ".right"},   32'(o_rsound_in), 32'(m_r));
    check({tag, ".overrun"}, 32'(o_overrun),   32'(m_ovr));
  endtask

  task automatic check_accepted(input string tag);
    logic [31:0] obs;
    check({tag, ".count"}, 32'(acc_q.size()), 32'(exp_acc_q.size()));
    for (int i = 0; i < exp_acc_q.size(); i++) begin
      if (i < acc_q.size()) obs = acc_q[i];
      else                  obs = 'x;
      check($sformatf("%s.pair%0d", tag, i), obs, exp_acc_q[i]);
    end
    acc_q.delete();
    exp_acc_q.delete();
  endtask

  // Model of a pair being published. pub_rdy is i_ready in the publish
  // cycle; rdy_after says whether the new pair is taken right afterwards.
  task automatic model_publish(input logic [15:0] l, input logic [15:0] r,
                               input logic pub_rdy, input logic rdy_after);
    if (m_valid) begin
      if (pub_rdy) exp_acc_q.push_back({m_l, m_r});
      else         m_ovr = 1'b1;
    end
    m_l     = l;
    m_r     = r;
    m_valid = 1'b1;
    if (rdy_after) begin
      exp_acc_q.push_back({l, r});
      m_valid = 1'b0;
    end
  endtask

  task automatic set_ready(input logic v);
    i_ready = v;
    if (v && m_valid) begin
      exp_acc_q.push_back({m_l, m_r});
      m_valid = 1'b0;
    end
  endtask

  // One bit-clock period starting and ending on an OSC_CLK falling edge.
  task automatic bck_period(input logic lrck_v, input logic dat_v);
    int half;
    half        = $urandom_range(2, 4);
    iAUD_BCK    = 1'b0;
    iAUD_LRCK   = lrck_v;
    iAUD_ADCDAT = dat_v;
    repeat (half) @(negedge OSC_CLK);
    iAUD_BCK = 1'b1;
    repeat (half) @(negedge OSC_CLK);
  endtask

  task automatic send_bits(input logic lrck_v, input logic [31:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) bck_period(lrck_v, word[nbits-1-i]);
  endtask

  // One slot: delay bit then nbits data bits, MSB first.
  // mode 0: plain; mode 1: check publish latency on the delay bit;
  // mode 2: raise i_ready exactly in the publish cycle.
  task automatic send_slot(input logic lrck_v, input logic [31:0] word, input int nbits, input int mode);
    logic        prev_valid;
    logic [15:0] prev_l;
    logic [15:0] prev_r;
    logic        lr_edge;
    int          half;
    prev_valid = m_valid;
    prev_l     = m_l;
    prev_r     = m_r;
    lr_edge    = (lrck_v !== m_lrck);
    if (lr_edge && !lrck_v) begin
      if (m_have_right) begin
        if (mode == 2) model_publish(m_lw, m_rw, 1'b1, 1'b0);
        else           model_publish(m_lw, m_rw, i_ready, i_ready);
      end
      m_have_left  = 1'b1;
      m_have_right = 1'b0;
      m_lw         = justify(word, nbits);
    end else if (lr_edge && lrck_v && m_have_left) begin
      m_have_right = 1'b1;
      m_rw         = justify(word, nbits);
    end
    m_lrck = lrck_v;

    if (mode == 0) begin
      bck_period(lrck_v, 1'($urandom));
    end else begin
      half        = $urandom_range(2, 4);
      iAUD_BCK    = 1'b0;
      iAUD_LRCK   = lrck_v;
      iAUD_ADCDAT = 1'($urandom);
      repeat (half) @(negedge OSC_CLK);
      iAUD_BCK = 1'b1;
      for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
        @(posedge OSC_CLK);
        #1;
        if (k == SYNC_STAGES + 1) begin
          check($sformatf("lat_m%0d.valid_early", mode), 32'(o_valid), 32'(prev_valid));
          check($sformatf("lat_m%0d.left_early", mode), 32'(o_lsound_in), 32'(prev_l));
          check($sformatf("lat_m%0d.right_early", mode), 32'(o_rsound_in), 32'(prev_r));
          if (mode == 2) i_ready = 1'b1;
        end
        if (k == SYNC_STAGES + 2) begin
          if (mode == 2) i_ready = 1'b0;
          check_outputs($sformatf("lat_m%0d.pub", mode));
        end
      end
      @(negedge OSC_CLK);
    end
    send_bits(lrck_v, word, nbits);
  endtask

  initial begin
    logic [31:0] w;
    reset_reg_N  = 1'b0;
    iAUD_BCK     = 1'b0;
    iAUD_LRCK    = 1'b0;
    iAUD_ADCDAT  = 1'b0;
    i_ready      = 1'b0;
    i_clr_ovr    = 1'b0;
    m_lrck       = 1'b0;
    m_have_left  = 1'b0;
    m_have_right = 1'b0;
    m_lw         = '0;
    m_rw         = '0;
    m_valid      = 1'b0;
    m_l          = '0;
    m_r          = '0;
    m_ovr        = 1'b0;

    repeat (3) @(negedge OSC_CLK);
    check_outputs("reset");
    reset_reg_N = 1'b1;
    @(negedge OSC_CLK);

    // Partial frame is dropped; 0x8001/0x7FFE published with exact latency.
    send_slot(1'b0, $urandom, 16, 0);
    send_slot(1'b1, $urandom, 16, 0);
    send_slot(1'b0, 32'h8001 << 15, 31, 0);
    send_slot(1'b1, 32'h7FFE << 15, 31, 0);
    check_outputs("first_frame_pending");
    send_slot(1'b0, 32'h1234 << 15, 31, 1);
    check_outputs("first_pair");

    // Consumer always ready over three frames.
    set_ready(1'b1);
    repeat (2) @(negedge OSC_CLK);
    check_outputs("accept_first");
    send_slot(1'b1, 32'hABCD << 15, 31, 0);
    send_slot(1'b0, 32'h0001 << 15, 31, 0);
    send_slot(1'b1, 32'h0002 << 15, 31, 0);
    send_slot(1'b0, 32'hFFFF << 15, 31, 0);
    send_slot(1'b1, 32'h0000 << 15, 31, 0);
    send_slot(1'b0, $urandom, 31, 0);
    check_outputs("ready_frames");
    check_accepted("ready_frames");

    // Consumer stalled over two frames: overwrite raises overrun.
    set_ready(1'b0);
    send_slot(1'b1, $urandom, 31, 0);
    send_slot(1'b0, $urandom, 31, 0);
    check_outputs("stall_one");
    send_slot(1'b1, $urandom, 31, 0);
    send_slot(1'b0, $urandom, $urandom_range(16, 31), 0);
    check_outputs("stall_overrun");
    i_clr_ovr = 1'b1;
    @(negedge OSC_CLK);
    i_clr_ovr = 1'b0;
    m_ovr     = 1'b0;
    check_outputs("overrun_cleared");
    set_ready(1'b1);
    @(negedge OSC_CLK);
    set_ready(1'b0);
    check_outputs("stall_accepted");
    check_accepted("stall");

    // Short 12-bit slot and long 32-bit slot.
    send_slot(1'b1, $urandom, 31, 0);
    send_slot(1'b0, 32'h0000_0ABC, 12, 0);
    set_ready(1'b1);
    @(negedge OSC_CLK);
    set_ready(1'b0);
    send_slot(1'b1, 32'hDEAD_BEEF, 32, 0);
    send_slot(1'b0, $urandom, 20, 0);
    check_outputs("short_long");
    check("short_long.left_value", 32'(o_lsound_in), 32'h0000_ABC0);
    check("short_long.right_value", 32'(o_rsound_in), 32'h0000_DEAD);

    // Publish in the same cycle as an accept.
    send_slot(1'b1, $urandom, 31, 0);
    send_slot(1'b0, $urandom, 31, 2);
    check_outputs("coincident");
    check_accepted("coincident");

    // Randomised frames with random slot lengths and consumer readiness.
    for (int f = 0; f < 4; f++) begin
      set_ready(1'($urandom));
      send_slot(1'b1, $urandom, $urandom_range(8, 32), 0);
      send_slot(1'b0, $urandom, $urandom_range(8, 32), 0);
      check_outputs($sformatf("random%0d", f));
    end
    set_ready(1'b1);
    @(negedge OSC_CLK);
    check_accepted("random");

    // Reset in the middle of a right slot with a pair pending and overrun set.
    set_ready(1'b0);
    send_slot(1'b1, $urandom, 31, 0);
    send_slot(1'b0, $urandom, 31, 0);
    send_slot(1'b1, $urandom, 31, 0);
    send_slot(1'b0, $urandom, 31, 0);
    check_outputs("pre_reset");
    w = $urandom;
    send_slot(1'b1, w, 10, 0);
    reset_reg_N = 1'b0;
    #1;
    m_valid      = 1'b0;
    m_l          = '0;
    m_r          = '0;
    m_ovr        = 1'b0;
    m_have_left  = 1'b0;
    m_have_right = 1'b0;
    exp_acc_q.delete();
    acc_q.delete();
    check_outputs("mid_reset");
    repeat (3) @(negedge OSC_CLK);
    reset_reg_N = 1'b1;
    send_bits(1'b1, $urandom, 12);
    send_slot(1'b0, $urandom, 31, 0);
    check_outputs("resync_left");
    send_slot(1'b1, $urandom, 31, 0);
    check_outputs("resync_right");
    send_slot(1'b0, $urandom, 31, 0);
    check_outputs("resync_pub");
    check_accepted("resync");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
